vector_frame_buffer: RTL

VECTOR_FRAME_BUFFER -- requirements
Module: vector_frame_buffer

---
 rtl/vector_frame_buffer_if.sv | 31 +++
 rtl/vector_frame_buffer.sv | 106 ++++++++++
 2 files changed

// File: rtl/vector_frame_buffer_if.sv
// Vector frame buffer bus: display read port, producer write port
// and swap status, grouped for the producer (master) and buffer (slave).
interface vector_frame_buffer_if #(
  parameter int ADDRESSWIDTH = 4,
  parameter int DATAWIDTH    = 18
);
  logic [ADDRESSWIDTH-1:0] rd_addr;
  logic [DATAWIDTH-1:0]    rd_data;
  logic                    frame_end;
  logic                    wr_en;
  logic [ADDRESSWIDTH-1:0] wr_addr;
  logic [DATAWIDTH-1:0]    wr_data;
  logic                    commit;
  logic                    wr_ready;
  logic                    swapped;
  logic                    front_bank;

  modport master (
    output rd_addr, frame_end, wr_en,
    output wr_addr, wr_data, commit,
    input  rd_data, wr_ready, swapped,
    input  front_bank
  );

  modport slave (
    input  rd_addr, frame_end, wr_en,
    input  wr_addr, wr_data, commit,
    output rd_data, wr_ready, swapped,
    output front_bank
  );
endinterface

// File: rtl/vector_frame_buffer.sv
// Double-buffered vector list, swapped on display frame_end after commit.
// Define VFB_COPY_ON_SWAP_EN to copy the new front into the back after a swap.
module vector_frame_buffer #(
  parameter int ADDRESSWIDTH = 4,
  parameter int DATAWIDTH    = 18
) (
  input logic clk,
  input logic rst,
  vector_frame_buffer_if.slave bus
);
  localparam int DEPTH = 2**ADDRESSWIDTH;

`ifdef VFB_COPY_ON_SWAP_EN
  typedef enum logic [1:0] {
    IDLE, PENDING, COPY
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, PENDING
  } state_t;
`endif

  state_t state, state_nx;
  logic   fb;
  logic   back;
  logic   swap;
  logic   wr_do;
  logic [DATAWIDTH-1:0] mem [2][DEPTH];

`ifdef VFB_COPY_ON_SWAP_EN
  logic [ADDRESSWIDTH-1:0] idx;
  logic                    cp_do;
`endif

  assign back = ~fb;

  always_comb begin
    state_nx     = state;
    swap         = 1'b0;
    wr_do        = 1'b0;
    bus.wr_ready = 1'b0;
`ifdef VFB_COPY_ON_SWAP_EN
    cp_do        = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        bus.wr_ready = 1'b1;
        wr_do        = bus.wr_en;
        if (bus.commit) state_nx = PENDING;
      end
      PENDING: begin
        if (bus.frame_end) begin
          swap = 1'b1;
`ifdef VFB_COPY_ON_SWAP_EN
          state_nx = COPY;
`else
          state_nx = IDLE;
`endif
        end
      end
`ifdef VFB_COPY_ON_SWAP_EN
      COPY: begin
        cp_do = 1'b1;
        if (&idx) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fb          <= 1'b0;
      bus.swapped <= 1'b0;
    end else begin
      state       <= state_nx;
      bus.swapped <= swap;
      if (swap) fb <= ~fb;
    end
  end

`ifdef VFB_COPY_ON_SWAP_EN
  // Held at zero outside COPY so every copy pass starts at entry 0
  always_ff @(posedge clk) begin
    if (rst || !cp_do) idx <= '0;
    else               idx <= idx + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < DEPTH; i++)
          mem[b][i] <= '0;
    end else begin
      if (wr_do) mem[back][bus.wr_addr] <= bus.wr_data;
`ifdef VFB_COPY_ON_SWAP_EN
      if (cp_do) mem[back][idx] <= mem[fb][idx];
`endif
    end
  end

  assign bus.rd_data    = mem[fb][bus.rd_addr];
  assign bus.front_bank = fb;
endmodule
